// File: rtl/pipeline_ctrl.sv
// Central stall/flush/redirect controller for the five-stage MIPS pipeline.
// Prioritises stage stall requests, turns ID branch decisions into PC redirects, and tracks delay slots.
module pipeline_ctrl #(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_stall_req,
  input  logic              id_stall_req,
  input  logic              ex_stall_req,
  input  logic              mem_stall_req,
  input  logic              branch_flag,
  input  logic [ADDR_W-1:0] branch_addr,
  input  logic              next_inst_delayslot_flag,
  input  logic              exc_flag,
  input  logic [ADDR_W-1:0] exc_pc,
  output logic [4:0]        stall,
  output logic              flush,
  output logic              pc_redirect,
  output logic [ADDR_W-1:0] pc_redirect_addr,
  output logic              id_delayslot_flag
);

  typedef enum logic {RUN, BR_PEND} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] tgt_q, tgt_d;
  logic              ds_pend_q, ds_pend_d;
  logic              id_ds_q, id_ds_d;
  logic [4:0]        stall_raw;
  logic              id_adv, fetch_ok, ds_set;
  logic              flush_raw, redirect_raw;
  logic [ADDR_W-1:0] redirect_addr_raw;

  always_comb begin
    stall_raw = '0;
    if (exc_flag)           stall_raw = 5'b00000;
    else if (mem_stall_req) stall_raw = 5'b01111;
    else if (ex_stall_req)  stall_raw = 5'b00111;
    else if (id_stall_req)  stall_raw = 5'b00011;
    else if (if_stall_req)  stall_raw = 5'b00001;
  end

  assign id_adv   = !stall_raw[1] && !exc_flag;
  assign fetch_ok = !stall_raw[0] && !exc_flag;
  assign ds_set   = next_inst_delayslot_flag && id_adv;

  always_comb begin
    state_d           = state_q;
    tgt_d             = tgt_q;
    flush_raw         = 1'b0;
    redirect_raw      = 1'b0;
    redirect_addr_raw = RESET_PC;
    if (exc_flag) begin
      flush_raw         = 1'b1;
      redirect_raw      = 1'b1;
      redirect_addr_raw = exc_pc;
      state_d           = RUN;
      tgt_d             = '0;
    end else begin
      unique case (state_q)
        RUN: begin
          if (branch_flag && id_adv) begin
            if (!if_stall_req) begin
              redirect_raw      = 1'b1;
              redirect_addr_raw = branch_addr;
            end else begin
              tgt_d   = branch_addr;
              state_d = BR_PEND;
            end
          end
        end
        BR_PEND: begin
          // Target held until the delay-slot fetch completes; new branches ignored.
          redirect_addr_raw = tgt_q;
          if (!if_stall_req && !stall_raw[0]) begin
            redirect_raw = 1'b1;
            state_d      = RUN;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_comb begin
    id_ds_d   = id_ds_q;
    ds_pend_d = ds_pend_q;
    if (exc_flag) begin
      id_ds_d   = 1'b0;
      ds_pend_d = 1'b0;
    end else if (!stall_raw[1]) begin
      if (fetch_ok) begin
        id_ds_d   = ds_pend_q;
        ds_pend_d = ds_set;
      end else begin
        // Bubble enters IF/ID: it is never a delay slot, the pending mark waits.
        id_ds_d   = 1'b0;
        ds_pend_d = ds_pend_q | ds_set;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RUN;
      tgt_q     <= '0;
      ds_pend_q <= 1'b0;
      id_ds_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      tgt_q     <= tgt_d;
      ds_pend_q <= ds_pend_d;
      id_ds_q   <= id_ds_d;
    end
  end

  // Combinational outputs are forced to their idle values while reset is held.
  assign stall             = rst ? '0 : stall_raw;
  assign flush             = rst ? 1'b0 : flush_raw;
  assign pc_redirect       = rst ? 1'b0 : redirect_raw;
  assign pc_redirect_addr  = rst ? RESET_PC : redirect_addr_raw;
  assign id_delayslot_flag = id_ds_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl: stall priority table plus branch/exception/reset sequences.
module tb_pipeline_ctrl;

  localparam logic [31:0] RPC = 32'hBFC0_0000;
  localparam logic [31:0] EPC = 32'hBFC0_0380;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_stall_req, id_stall_req, ex_stall_req, mem_stall_req;
  logic        branch_flag, next_inst_delayslot_flag, exc_flag;
  logic [31:0] branch_addr, exc_pc;
  logic [4:0]  stall;
  logic        flush, pc_redirect, id_delayslot_flag;
  logic [31:0] pc_redirect_addr;

  int unsigned pass_cnt = 0;
  int unsigned total    = 0;

  pipeline_ctrl #(.ADDR_W(32), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst),
    .if_stall_req(if_stall_req), .id_stall_req(id_stall_req),
    .ex_stall_req(ex_stall_req), .mem_stall_req(mem_stall_req),
    .branch_flag(branch_flag), .branch_addr(branch_addr),
    .next_inst_delayslot_flag(next_inst_delayslot_flag),
    .exc_flag(exc_flag), .exc_pc(exc_pc),
    .stall(stall), .flush(flush), .pc_redirect(pc_redirect),
    .pc_redirect_addr(pc_redirect_addr), .id_delayslot_flag(id_delayslot_flag)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        ifs, ids, exs, mems, exc, br;
    logic [31:0] baddr;
    logic [4:0]  e_stall;
    logic        e_flush, e_redir;
    logic [31:0] e_addr;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic clear_in();
    if_stall_req = 0; id_stall_req = 0; ex_stall_req = 0; mem_stall_req = 0;
    branch_flag = 0; next_inst_delayslot_flag = 0; exc_flag = 0;
    branch_addr = '0; exc_pc = EPC;
  endtask

  task automatic chk_comb(input string nm, input logic [4:0] s, input logic f,
                          input logic r, input logic [31:0] a);
    chk({nm, ".stall"}, {27'd0, stall}, {27'd0, s});
    chk({nm, ".flush"}, {31'd0, flush}, {31'd0, f});
    chk({nm, ".redir"}, {31'd0, pc_redirect}, {31'd0, r});
    chk({nm, ".addr"}, pc_redirect_addr, a);
  endtask

  initial begin
    //           if id ex mem exc br  baddr          stall     fl rd addr
    vecs[0]  = '{0, 0, 0, 0, 0, 0, 32'h0,        5'b00000, 0, 0, RPC};
    vecs[1]  = '{1, 0, 0, 0, 0, 0, 32'h0,        5'b00001, 0, 0, RPC};
    vecs[2]  = '{0, 1, 0, 0, 0, 0, 32'h0,        5'b00011, 0, 0, RPC};
    vecs[3]  = '{0, 0, 1, 0, 0, 0, 32'h0,        5'b00111, 0, 0, RPC};
    vecs[4]  = '{0, 0, 0, 1, 0, 0, 32'h0,        5'b01111, 0, 0, RPC};
    vecs[5]  = '{0, 1, 1, 0, 0, 0, 32'h0,        5'b00111, 0, 0, RPC};
    vecs[6]  = '{0, 1, 1, 1, 0, 0, 32'h0,        5'b01111, 0, 0, RPC};
    vecs[7]  = '{0, 1, 1, 1, 1, 0, 32'h0,        5'b00000, 1, 1, EPC};
    vecs[8]  = '{1, 1, 1, 1, 1, 1, 32'h8000_0500, 5'b00000, 1, 1, EPC};
    vecs[9]  = '{0, 0, 0, 0, 0, 1, 32'h8000_0400, 5'b00000, 0, 1, 32'h8000_0400};
    vecs[10] = '{0, 1, 0, 0, 0, 1, 32'h8000_0600, 5'b00011, 0, 0, RPC};
    vecs[11] = '{1, 0, 0, 1, 0, 1, 32'h8000_0700, 5'b01111, 0, 0, RPC};
    vecs[12] = '{1, 0, 1, 0, 0, 0, 32'h0,        5'b00111, 0, 0, RPC};

    clear_in();
    rst = 1;
    mem_stall_req = 1; branch_flag = 1; branch_addr = 32'h8000_0900;
    #1;
    chk_comb("reset", 5'b00000, 0, 0, RPC);
    chk("reset.ids", {31'd0, id_delayslot_flag}, 32'd0);
    @(negedge clk); rst = 0; clear_in();

    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      clear_in();
      {if_stall_req, id_stall_req, ex_stall_req, mem_stall_req, exc_flag, branch_flag} =
        {vecs[i].ifs, vecs[i].ids, vecs[i].exs, vecs[i].mems, vecs[i].exc, vecs[i].br};
      branch_addr = vecs[i].baddr;
      #1;
      chk_comb($sformatf("vec%0d", i), vecs[i].e_stall, vecs[i].e_flush, vecs[i].e_redir, vecs[i].e_addr);
    end

    // Branch with no stall, delay slot marked one fetch later for one instruction.
    @(negedge clk); clear_in();
    branch_flag = 1; branch_addr = 32'h8000_0100; next_inst_delayslot_flag = 1;
    #1 chk_comb("br0", 5'b00000, 0, 1, 32'h8000_0100);
    @(negedge clk); clear_in();
    #1 chk("br0.ids_a", {31'd0, id_delayslot_flag}, 32'd0);
    chk_comb("br0.after", 5'b00000, 0, 0, RPC);
    @(negedge clk);
    #1 chk("br0.ids_b", {31'd0, id_delayslot_flag}, 32'd1);
    @(negedge clk);
    #1 chk("br0.ids_c", {31'd0, id_delayslot_flag}, 32'd0);

    // Branch under IF stall for 3 cycles; single pulse in cycle 4.
    @(negedge clk); clear_in();
    branch_flag = 1; branch_addr = 32'h8000_0200; next_inst_delayslot_flag = 1; if_stall_req = 1;
    #1 chk_comb("bp.c1", 5'b00001, 0, 0, RPC);
    @(negedge clk); clear_in(); if_stall_req = 1;
    branch_flag = 1; branch_addr = 32'h9000_0000;
    #1 chk_comb("bp.c2", 5'b00001, 0, 0, 32'h8000_0200);
    @(negedge clk); clear_in(); if_stall_req = 1;
    #1 chk_comb("bp.c3", 5'b00001, 0, 0, 32'h8000_0200);
    chk("bp.ids3", {31'd0, id_delayslot_flag}, 32'd0);
    @(negedge clk); clear_in();
    branch_flag = 1; branch_addr = 32'h9000_0000;
    #1 chk_comb("bp.c4", 5'b00000, 0, 1, 32'h8000_0200);
    @(negedge clk); clear_in();
    #1 chk_comb("bp.c5", 5'b00000, 0, 0, RPC);
    chk("bp.ids5", {31'd0, id_delayslot_flag}, 32'd1);
    @(negedge clk);
    #1 chk("bp.ids6", {31'd0, id_delayslot_flag}, 32'd0);

    // Exception while a redirect is pending.
    @(negedge clk); clear_in();
    branch_flag = 1; branch_addr = 32'h8000_0300; next_inst_delayslot_flag = 1; if_stall_req = 1;
    @(negedge clk); clear_in(); if_stall_req = 1; exc_flag = 1; exc_pc = EPC;
    #1 chk_comb("exc", 5'b00000, 1, 1, EPC);
    @(negedge clk); clear_in();
    #1 chk_comb("exc.after", 5'b00000, 0, 0, RPC);
    chk("exc.ids", {31'd0, id_delayslot_flag}, 32'd0);
    @(negedge clk);
    #1 chk("exc.ids2", {31'd0, id_delayslot_flag}, 32'd0);
    chk("exc.redir2", {31'd0, pc_redirect}, 32'd0);

    // Delay-slot flag held across an ID stall.
    @(negedge clk); clear_in();
    branch_flag = 1; branch_addr = 32'h8000_0800; next_inst_delayslot_flag = 1;
    #1 chk("dsh.redir", {31'd0, pc_redirect}, 32'd1);
    @(negedge clk); clear_in();
    @(negedge clk); clear_in(); id_stall_req = 1;
    #1 chk("dsh.ids1", {31'd0, id_delayslot_flag}, 32'd1);
    @(negedge clk); clear_in(); id_stall_req = 1;
    #1 chk("dsh.ids2", {31'd0, id_delayslot_flag}, 32'd1);
    @(negedge clk); clear_in();
    #1 chk("dsh.ids3", {31'd0, id_delayslot_flag}, 32'd1);
    @(negedge clk);
    #1 chk("dsh.ids4", {31'd0, id_delayslot_flag}, 32'd0);

    // Asynchronous reset while a redirect is pending.
    @(negedge clk); clear_in();
    branch_flag = 1; branch_addr = 32'h8000_0A00; if_stall_req = 1;
    @(negedge clk); clear_in(); if_stall_req = 1;
    #1 chk("rbp.addr", pc_redirect_addr, 32'h8000_0A00);
    #1 rst = 1;
    #1 chk_comb("rbp.rst", 5'b00000, 0, 0, RPC);
    @(negedge clk); rst = 0; clear_in();
    #1 chk_comb("rbp.rel1", 5'b00000, 0, 0, RPC);
    @(negedge clk);
    #1 chk_comb("rbp.rel2", 5'b00000, 0, 0, RPC);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
